// File: rtl/txmsg_pkg.sv
// txmsg_pkg: shared constants, FSM state type and helpers for txmsg.
// Baud divisors are clock tics per serial bit for a 12 MHz system clock.
package txmsg_pkg;

    localparam int B115200 = 104;

    // start bit + 8 data bits + stop bit
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_GAP
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serialiser (LSB first) with a start/ready handshake.
// Ports: clk_i, rstn_i (async, active-low); start_i/data_i load a character
// when ready_o is high; fin_o flags the cycle before the final stop-bit
// cycle; tx_o is the registered serial line (idle high).
module uart_tx_core
    import txmsg_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       fin_o,
    output logic       tx_o
);

    localparam int BW = cnt_w(BAUDRATE);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUDRATE - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUDRATE - 2);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic                  act_q, act_d;
    logic                  tx_q, tx_d;
    logic                  tick, last_bit;

    assign tick     = (baud_q == BAUD_LAST);
    assign last_bit = (bit_q == BIT_LAST);

    // Ready during the final stop-bit cycle so back-to-back frames abut.
    assign ready_o = !act_q || (tick && last_bit);
    assign fin_o   = act_q && last_bit && (baud_q == BAUD_PRE);
    assign tx_o    = tx_q;

    always_comb begin
        sh_d   = sh_q;
        baud_d = baud_q;
        bit_d  = bit_q;
        act_d  = act_q;
        tx_d   = tx_q;
        if (start_i && ready_o) begin
            // The baud counter restarts so the frame aligns to its start bit.
            sh_d   = {1'b1, data_i, 1'b0};
            baud_d = '0;
            bit_d  = '0;
            act_d  = 1'b1;
            tx_d   = 1'b0;
        end else if (act_q) begin
            if (tick) begin
                baud_d = '0;
                if (last_bit) begin
                    act_d = 1'b0;
                    tx_d  = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    sh_d  = {1'b1, sh_q[FRAME_BITS-1:1]};
                    // sh_q[0] is on the line now; sh_q[1] goes next.
                    tx_d  = sh_q[1];
                end
            end else begin
                baud_d = baud_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_q   <= '1;
            baud_q <= '0;
            bit_q  <= '0;
            act_q  <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            sh_q   <= sh_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
            act_q  <= act_d;
            tx_q   <= tx_d;
        end
    end

endmodule

// File: rtl/txmsg.sv
// txmsg: sends a compile-time ASCII string over a UART line on trigger,
// optionally repeating with an idle gap while start stays high.
// Ports: clk, rstn (async, active-low), start (level trigger, sampled
// while idle); tx (serial line, idle high), busy (message or gap in
// progress), done (one-cycle pulse after the last stop bit).
module txmsg
    import txmsg_pkg::*;
#(
    parameter int                 BAUDRATE = B115200,
    parameter int                 MSG_LEN  = 8,
    parameter logic [8*MSG_LEN-1:0] MSG    = "Hello!\r\n",
    parameter int                 MODE     = 0,
    parameter int                 GAP      = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic tx,
    output logic busy,
    output logic done
);

    localparam int IW      = cnt_w(MSG_LEN);
    localparam int GAP_CYC = (GAP > 0) ? GAP * BAUDRATE : 1;
    localparam int GW      = cnt_w(GAP_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam bit USE_GAP = (MODE == 1) && (GAP > 0);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          start_q;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          core_go, core_rdy, core_fin;
    logic [IW-1:0] sel;
    logic [7:0]    chr;
    logic          last_chr;

    assign last_chr = (idx_q == IDX_LAST);

    // Character 0 is the leftmost literal character (most significant byte).
    assign chr = 8'(MSG >> (8 * (MSG_LEN - 1 - int'(sel))));

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        core_go = 1'b0;
        sel     = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (core_rdy) begin
                    core_go = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (core_fin) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // This is the final stop-bit cycle: the next character is
                // handed to the core here so no idle cycle separates them.
                if (!last_chr) begin
                    sel     = idx_q + IW'(1);
                    idx_d   = idx_q + IW'(1);
                    core_go = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    done_d = 1'b1;
                    if (USE_GAP) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            start_q <= start;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    uart_tx_core #(
        .BAUDRATE(BAUDRATE)
    ) u_core (
        .clk_i  (clk),
        .rstn_i (rstn),
        .start_i(core_go),
        .data_i (chr),
        .ready_o(core_rdy),
        .fin_o  (core_fin),
        .tx_o   (tx)
    );

endmodule
